// File: rtl/sine_dac_sequencer.sv
// sine_dac_sequencer: drives an 8-bit offset-binary DAC from a phase
// accumulator and an external quarter-wave sine ROM.
//
// Each sample period (CLK_DIV clocks) the sequencer:
//   1. latches the tuning word and presents the mirrored ROM address
//   2. waits one cycle for the synchronous ROM read
//   3. rebuilds the full-wave code on dac_data and advances the phase
//   4. pulses dac_clk for one cycle
// When en is low at a sample tick, the output is parked at midscale with
// one final dac_clk pulse before returning to IDLE.
//
// Optional build macro AMP_SCALE_EN adds an 8-bit amplitude input that
// scales the ROM magnitude by amp/256.
module sine_dac_sequencer #(
    parameter int CLK_DIV = 8,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] freq_word,
`ifdef AMP_SCALE_EN
    input  logic [7:0]         amp,
`endif
    output logic [LUT_AW-1:0]  rom_addr,
    input  logic [6:0]         rom_data,
    output logic [7:0]         dac_data,
    output logic               dac_clk,
    output logic               busy,
    output logic [15:0]        sample_cnt
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]  MIDSCALE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FETCH,
        WAIT,
        UPDATE,
        STROBE,
        PARK,
        PARK2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [15:0]        divider;
    logic               tick;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] fw_lat;
    logic [1:0]         quad;
    logic [LUT_AW-1:0]  idx;
    logic [6:0]         mag;
    logic [7:0]         code;

    // One-cycle control strobes decoded from the state and tick
    logic               start_run;
    logic               fetch_go;
    logic               park_go;

`ifdef AMP_SCALE_EN
    logic [7:0]         amp_lat;
`endif

    assign tick = (divider == 16'd0);
    assign busy = (state != IDLE);

    // Position inside the current quadrant; odd quadrants read the table
    // backwards so only a quarter wave has to be stored.
    assign idx = phase[PHASE_W-3 -: LUT_AW];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-transition control strobes
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        fetch_go   = 1'b0;
        park_go    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
                // en only matters on the tick, so short glitches between
                // ticks never disturb a running waveform.
                if (tick) begin
                    if (en) begin
                        state_next = FETCH;
                        fetch_go   = 1'b1;
                    end else begin
                        state_next = PARK;
                        park_go    = 1'b1;
                    end
                end
            end
            FETCH:   state_next = WAIT;
            WAIT:    state_next = UPDATE;
            UPDATE:  state_next = STROBE;
            STROBE:  state_next = RUN;
            PARK:    state_next = PARK2;
            PARK2:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sample-period divider; held at zero in IDLE so RUN starts on a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            divider <= 16'd0;
        end else if (state == IDLE) begin
            divider <= 16'd0;
        end else if (divider == DIV_LAST) begin
            divider <= 16'd0;
        end else begin
            divider <= divider + 16'd1;
        end
    end

    // Sample start: capture tuning word, quadrant and ROM address together
    // so a freq_word change mid-sample only lands at the next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            fw_lat   <= '0;
            quad     <= 2'd0;
            rom_addr <= '0;
        end else if (fetch_go) begin
            fw_lat   <= freq_word;
            quad     <= phase[PHASE_W-1 -: 2];
            rom_addr <= phase[PHASE_W-2] ? ~idx : idx;
        end
    end

`ifdef AMP_SCALE_EN
    // Amplitude is captured at the same point as the tuning word
    always_ff @(posedge clk) begin
        if (rst) begin
            amp_lat <= 8'd0;
        end else if (fetch_go) begin
            amp_lat <= amp;
        end
    end

    // 7x8 product keeps its top 7 bits: amp=0xFF tops out at 126
    always_comb begin
        mag = 7'(({8'd0, rom_data} * {7'd0, amp_lat}) >> 8);
    end
`else
    // Full-scale magnitude straight from the ROM
    always_comb begin
        mag = rom_data;
    end
`endif

    // Upper half of the wave sits above midscale, lower half mirrors below
    always_comb begin
        if (quad[1]) begin
            code = 8'h7F - {1'b0, mag};
        end else begin
            code = 8'h80 + {1'b0, mag};
        end
    end

    // Phase accumulator: advanced once the current sample's address has
    // been used, cleared when parking so a restart begins at zero phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (park_go) begin
            phase <= '0;
        end else if (state == WAIT) begin
            phase <= phase + fw_lat;
        end
    end

    // DAC data: new code is visible one full cycle before its strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_data <= MIDSCALE;
        end else if (state == WAIT) begin
            dac_data <= code;
        end else if (park_go || state == IDLE) begin
            dac_data <= MIDSCALE;
        end
    end

    // DAC strobe: single-cycle pulse after the data has settled
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_clk <= 1'b0;
        end else begin
            dac_clk <= (state == UPDATE) || (state == PARK);
        end
    end

    // Count of waveform strobes since the run began; the park strobe is
    // deliberately excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= 16'd0;
        end else if (start_run) begin
            sample_cnt <= 16'd0;
        end else if (state == UPDATE) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sine_dac_sequencer.sv
// Bench for sine_dac_sequencer: random ROM contents and tuning words,
// expected DAC codes computed from the sample phase with plain arithmetic.
module tb_sine_dac_sequencer;

    localparam int CLK_DIV = 8;
    localparam int PHASE_W = 16;
    localparam int LUT_AW  = 6;
    localparam int BUDGET  = 4 * CLK_DIV;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [PHASE_W-1:0] freq_word;
    logic [LUT_AW-1:0]  rom_addr;
    logic [6:0]         rom_data;
    logic [7:0]         dac_data;
    logic               dac_clk;
    logic               busy;
    logic [15:0]        sample_cnt;
`ifdef AMP_SCALE_EN
    logic [7:0]         amp;
`endif

    logic [6:0]         rom_mem [1<<LUT_AW];
    logic [7:0]         prev_data;
    logic               prev_clk;
    logic [PHASE_W-1:0] m_phase;
    int                 cyc = 0;
    int                 checks = 0;
    int                 failures = 0;

    always #5 clk = ~clk;

    // External ROM with one-cycle registered read, cycle counter, and the
    // previous-cycle DAC outputs for setup/pulse-width checks.
    always @(posedge clk) begin
        rom_data  <= rom_mem[rom_addr];
        cyc       <= cyc + 1;
        prev_data <= dac_data;
        prev_clk  <= dac_clk;
    end

    sine_dac_sequencer #(
        .CLK_DIV (CLK_DIV),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .freq_word  (freq_word),
`ifdef AMP_SCALE_EN
        .amp        (amp),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dac_data   (dac_data),
        .dac_clk    (dac_clk),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    // Table position for a phase: quarter-wave index, read backwards in
    // the second and fourth quadrants.
    function automatic logic [LUT_AW-1:0] exp_addr(input logic [PHASE_W-1:0] ph);
        int quad, pos;
        quad = int'(ph) >> (PHASE_W - 2);
        pos  = (int'(ph) % (1 << (PHASE_W - 2))) >> (PHASE_W - 2 - LUT_AW);
        if (quad % 2 == 1) pos = (1 << LUT_AW) - 1 - pos;
        return LUT_AW'(pos);
    endfunction

    // Offset-binary sine code for a phase
    function automatic logic [7:0] exp_code(input logic [PHASE_W-1:0] ph);
        int mag, quad;
        mag = int'(rom_mem[exp_addr(ph)]);
`ifdef AMP_SCALE_EN
        mag = (mag * int'(amp)) / 256;
`endif
        quad = int'(ph) >> (PHASE_W - 2);
        return (quad < 2) ? 8'(128 + mag) : 8'(127 - mag);
    endfunction

    task automatic wait_strobe(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (dac_clk === 1'b1) got = 1'b1;
        end
    endtask

    task automatic stop_and_idle();
        bit idle;
        idle = 1'b0;
        en = 1'b0;
        for (int i = 0; i < BUDGET && !idle; i++) begin
            @(negedge clk);
            idle = (busy === 1'b0);
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL stop_idle: busy=%b after %0d cycles, required 0", busy, BUDGET);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        freq_word = 16'h0400;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dac_data !== 8'h80 || dac_clk !== 1'b0 || busy !== 1'b0 || sample_cnt !== 16'd0) begin
                failures++;
                $display("FAIL reset: data=%h clk=%b busy=%b cnt=%0d, required 80/0/0/0",
                         dac_data, dac_clk, busy, sample_cnt);
            end
        end
        en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_quarter_wave();
        bit got;
        int prev_cyc;
        for (int i = 0; i < (1 << LUT_AW); i++) rom_mem[i] = 7'(2 * i);
        freq_word = 16'h0400;
        m_phase = '0;
        prev_cyc = -1;
        en = 1'b1;
        for (int k = 0; k < 68; k++) begin
            wait_strobe(BUDGET, got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL qw_timeout: sample %0d no dac_clk, required one within %0d", k, BUDGET);
                break;
            end
            checks++;
            if (dac_data !== exp_code(m_phase)) begin
                failures++;
                $display("FAIL qw_code: sample %0d data=%h, required %h", k, dac_data, exp_code(m_phase));
            end
            checks++;
            if (rom_addr !== exp_addr(m_phase)) begin
                failures++;
                $display("FAIL qw_addr: sample %0d addr=%0d, required %0d", k, rom_addr, exp_addr(m_phase));
            end
            checks++;
            if (prev_data !== dac_data || prev_clk !== 1'b0) begin
                failures++;
                $display("FAIL qw_setup: sample %0d prev data=%h clk=%b, required %h/0",
                         k, prev_data, prev_clk, dac_data);
            end
            checks++;
            if (sample_cnt !== 16'(k + 1)) begin
                failures++;
                $display("FAIL qw_count: sample %0d cnt=%0d, required %0d", k, sample_cnt, k + 1);
            end
            if (prev_cyc >= 0) begin
                checks++;
                if (cyc - prev_cyc != CLK_DIV) begin
                    failures++;
                    $display("FAIL qw_spacing: sample %0d spacing=%0d, required %0d", k, cyc - prev_cyc, CLK_DIV);
                end
            end
            prev_cyc = cyc;
            m_phase = m_phase + 16'h0400;
        end
        stop_and_idle();
    endtask

    task automatic test_latency();
        bit got;
        logic [PHASE_W-1:0] fw, fw2;
        logic [7:0] c0, c1;
        fw  = 16'($urandom_range(1, 15) << 10);
        fw2 = 16'($urandom);
        c0  = exp_code(16'd0);
        c1  = exp_code(fw);
        freq_word = fw;
        en = 1'b1;
        wait_strobe(BUDGET, got);
        checks++;
        if (!got || dac_data !== c0) begin
            failures++;
            $display("FAIL lat_first: got=%b data=%h, required 1/%h", got, dac_data, c0);
        end
        repeat (CLK_DIV - 4) @(negedge clk);
        checks++;
        if (rom_addr !== exp_addr(16'd0) || dac_clk !== 1'b0 || dac_data !== c0) begin
            failures++;
            $display("FAIL lat_tick: addr=%0d clk=%b data=%h, required %0d/0/%h",
                     rom_addr, dac_clk, dac_data, exp_addr(16'd0), c0);
        end
        @(negedge clk);
        freq_word = fw2;
        checks++;
        if (rom_addr !== exp_addr(fw) || dac_data !== c0 || dac_clk !== 1'b0) begin
            failures++;
            $display("FAIL lat_t1: addr=%0d data=%h clk=%b, required %0d/%h/0",
                     rom_addr, dac_data, dac_clk, exp_addr(fw), c0);
        end
        @(negedge clk);
        checks++;
        if (dac_data !== c0 || dac_clk !== 1'b0) begin
            failures++;
            $display("FAIL lat_t2: data=%h clk=%b, required %h/0", dac_data, dac_clk, c0);
        end
        @(negedge clk);
        checks++;
        if (dac_data !== c1 || dac_clk !== 1'b0) begin
            failures++;
            $display("FAIL lat_t3: data=%h clk=%b, required %h/0", dac_data, dac_clk, c1);
        end
        @(negedge clk);
        checks++;
        if (dac_data !== c1 || dac_clk !== 1'b1) begin
            failures++;
            $display("FAIL lat_t4: data=%h clk=%b, required %h/1", dac_data, dac_clk, c1);
        end
        // fw2 arrived mid-sample, so it first affects the sample after next
        wait_strobe(BUDGET, got);
        checks++;
        if (!got || dac_data !== exp_code(16'(2 * fw))) begin
            failures++;
            $display("FAIL lat_fw_hold: got=%b data=%h, required 1/%h", got, dac_data, exp_code(16'(2 * fw)));
        end
        wait_strobe(BUDGET, got);
        checks++;
        if (!got || dac_data !== exp_code(16'(2 * fw + fw2))) begin
            failures++;
            $display("FAIL lat_fw_new: got=%b data=%h, required 1/%h", got, dac_data, exp_code(16'(2 * fw + fw2)));
        end
        stop_and_idle();
    endtask

    task automatic test_stop();
        bit got;
        logic [PHASE_W-1:0] fw;
        for (int i = 0; i < (1 << LUT_AW); i++) rom_mem[i] = 7'($urandom);
        fw = 16'($urandom);
        freq_word = fw;
        m_phase = '0;
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_strobe(BUDGET, got);
            checks++;
            if (!got || dac_data !== exp_code(m_phase)) begin
                failures++;
                $display("FAIL stop_run: sample %0d got=%b data=%h, required 1/%h", k, got, dac_data, exp_code(m_phase));
            end
            m_phase = m_phase + fw;
        end
        repeat (CLK_DIV - 2) @(negedge clk);
        en = 1'b0;
        wait_strobe(4, got);
        checks++;
        if (!got || dac_data !== exp_code(m_phase) || sample_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stop_inflight: got=%b data=%h cnt=%0d, required 1/%h/3",
                     got, dac_data, sample_cnt, exp_code(m_phase));
        end
        repeat (CLK_DIV - 3) @(negedge clk);
        checks++;
        if (dac_data !== 8'h80 || dac_clk !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stop_park: data=%h clk=%b busy=%b, required 80/0/1", dac_data, dac_clk, busy);
        end
        @(negedge clk);
        checks++;
        if (dac_data !== 8'h80 || dac_clk !== 1'b1) begin
            failures++;
            $display("FAIL stop_park_strobe: data=%h clk=%b, required 80/1", dac_data, dac_clk);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dac_clk !== 1'b0 || sample_cnt !== 16'd3 || dac_data !== 8'h80) begin
            failures++;
            $display("FAIL stop_idle_state: busy=%b clk=%b cnt=%0d data=%h, required 0/0/3/80",
                     busy, dac_clk, sample_cnt, dac_data);
        end
        // Restart must begin from zero phase
        en = 1'b1;
        wait_strobe(BUDGET, got);
        checks++;
        if (!got || dac_data !== exp_code(16'd0) || sample_cnt !== 16'd1) begin
            failures++;
            $display("FAIL stop_restart: got=%b data=%h cnt=%0d, required 1/%h/1",
                     got, dac_data, sample_cnt, exp_code(16'd0));
        end
        stop_and_idle();
    endtask

    task automatic test_reset_fetch();
        bit got;
        freq_word = 16'($urandom);
        en = 1'b1;
        for (int k = 0; k < 3; k++) wait_strobe(BUDGET, got);
        repeat (CLK_DIV - 3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sample_cnt !== 16'd3) begin
            failures++;
            $display("FAIL rst_prefetch: busy=%b cnt=%0d, required 1/3", busy, sample_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dac_clk !== 1'b0 || dac_data !== 8'h80 || sample_cnt !== 16'd0 || rom_addr !== '0) begin
            failures++;
            $display("FAIL rst_fetch: busy=%b clk=%b data=%h cnt=%0d addr=%0d, required 0/0/80/0/0",
                     busy, dac_clk, dac_data, sample_cnt, rom_addr);
        end
        en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit got;
        int prev_cyc;
        logic [PHASE_W-1:0] fw;
        for (int i = 0; i < (1 << LUT_AW); i++) rom_mem[i] = 7'($urandom);
`ifdef AMP_SCALE_EN
        amp = 8'($urandom);
`endif
        fw = 16'($urandom);
        freq_word = fw;
        m_phase = '0;
        prev_cyc = -1;
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int gap;
            wait_strobe(BUDGET, got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL rnd_timeout: sample %0d no dac_clk, required one within %0d", k, BUDGET);
                break;
            end
            checks++;
            if (dac_data !== exp_code(m_phase) || rom_addr !== exp_addr(m_phase)) begin
                failures++;
                $display("FAIL rnd_code: sample %0d data=%h addr=%0d, required %h/%0d",
                         k, dac_data, rom_addr, exp_code(m_phase), exp_addr(m_phase));
            end
            checks++;
            if (sample_cnt !== 16'(k + 1) || prev_clk !== 1'b0 || prev_data !== dac_data) begin
                failures++;
                $display("FAIL rnd_strobe: sample %0d cnt=%0d prev_clk=%b prev_data=%h, required %0d/0/%h",
                         k, sample_cnt, prev_clk, prev_data, k + 1, dac_data);
            end
            if (prev_cyc >= 0) begin
                checks++;
                if (cyc - prev_cyc != CLK_DIV) begin
                    failures++;
                    $display("FAIL rnd_spacing: sample %0d spacing=%0d, required %0d", k, cyc - prev_cyc, CLK_DIV);
                end
            end
            prev_cyc = cyc;
            m_phase = m_phase + fw;
            fw = 16'($urandom);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            freq_word = fw;
            if (gap == 0) begin
                // en pulse low between ticks must be ignored
                @(negedge clk);
                en = 1'b0;
                @(negedge clk);
                en = 1'b1;
            end
        end
        stop_and_idle();
    endtask

    task automatic test_phase_wrap();
        bit got;
        logic [PHASE_W-1:0] ph_tab [5];
        logic [7:0] hold;
        ph_tab = '{16'h0000, 16'hC000, 16'h8000, 16'h4000, 16'h0000};
        for (int i = 0; i < (1 << LUT_AW); i++) rom_mem[i] = 7'($urandom);
        freq_word = 16'hC000;
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_strobe(BUDGET, got);
            checks++;
            if (!got || dac_data !== exp_code(ph_tab[k])) begin
                failures++;
                $display("FAIL wrap_code: sample %0d got=%b data=%h, required 1/%h", k, got, dac_data, exp_code(ph_tab[k]));
            end
        end
        freq_word = 16'h0000;
        hold = exp_code(16'hC000);
        for (int k = 0; k < 4; k++) begin
            wait_strobe(BUDGET, got);
            checks++;
            if (!got || dac_data !== hold) begin
                failures++;
                $display("FAIL zero_fw: sample %0d got=%b data=%h, required 1/%h", k, got, dac_data, hold);
            end
        end
        stop_and_idle();
    endtask

`ifdef AMP_SCALE_EN
    task automatic test_amp();
        bit got;
        logic [7:0] want [3];
        logic [7:0] amps [3];
        logic [PHASE_W-1:0] fws [3];
        want = '{8'hBF, 8'h80, 8'h01};
        amps = '{8'h80, 8'h00, 8'hFF};
        fws  = '{16'h0000, 16'h0000, 16'h8000};
        for (int i = 0; i < (1 << LUT_AW); i++) rom_mem[i] = 7'd127;
        for (int t = 0; t < 3; t++) begin
            amp = amps[t];
            freq_word = fws[t];
            en = 1'b1;
            // second sample so the 0x8000 case lands in the lower half
            for (int k = 0; k <= (t == 2 ? 1 : 0); k++) wait_strobe(BUDGET, got);
            checks++;
            if (!got || dac_data !== want[t]) begin
                failures++;
                $display("FAIL amp_scale: amp=%h got=%b data=%h, required 1/%h", amps[t], got, dac_data, want[t]);
            end
            stop_and_idle();
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        en = 1'b0;
        freq_word = '0;
`ifdef AMP_SCALE_EN
        amp = 8'hFF;
`endif
        for (int i = 0; i < (1 << LUT_AW); i++) rom_mem[i] = 7'd0;
        test_reset();
        test_quarter_wave();
        test_latency();
        test_stop();
        test_reset_fetch();
        test_random();
        test_phase_wrap();
`ifdef AMP_SCALE_EN
        test_amp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
